// File: rtl/parking_controller_multi.sv
// parking_controller_multi: multi-slot gate FSM with occupancy, password retries, timeout and free-slot display (lockout enabled by PARKING_LOCKOUT_EN)
module parking_controller_multi #(
  parameter int CAPACITY = 8,
  parameter int PW_WIDTH = 4,
  parameter logic [PW_WIDTH-1:0] PASSWORD = 4'hA,
  parameter int MAX_TRIES = 3,
  parameter int TIMEOUT_CYC = 20,
  parameter int LOCK_CYC = 50,
  parameter int BLINK_DIV = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          sensor_entrance,
  input  logic                          sensor_pass,
  input  logic                          sensor_exit,
  input  logic [PW_WIDTH-1:0]           password,
  input  logic                          pw_valid,
  output logic                          GREEN_LED,
  output logic                          RED_LED,
  output logic [$clog2(CAPACITY+1)-1:0] occupancy,
  output logic                          full,
  output logic                          lockout,
  output logic [6:0]                    HEX_1,
  output logic [6:0]                    HEX_2
);
  localparam int OW = $clog2(CAPACITY + 1);
  localparam int TMAX = TIMEOUT_CYC > LOCK_CYC ? TIMEOUT_CYC : LOCK_CYC;
  localparam int TW = $clog2(TMAX + 1);
  localparam int RW = $clog2(MAX_TRIES + 1);
  localparam int BW = $clog2(BLINK_DIV + 1);
  localparam logic [OW-1:0] CAP = OW'(CAPACITY);
  localparam logic [OW-1:0] CAP_M1 = OW'(CAPACITY - 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [BW-1:0] BL_LAST = BW'(BLINK_DIV - 1);
`ifdef PARKING_LOCKOUT_EN
  localparam logic [TW-1:0] LK_LAST = TW'(LOCK_CYC - 1);
  localparam logic [RW-1:0] TRIES_LAST = RW'(MAX_TRIES - 1);
`endif
  typedef enum logic [2:0] {
    IDLE, WAIT_PASSWORD, WRONG_PASS, RIGHT_PASS, STOP
`ifdef PARKING_LOCKOUT_EN
    , LOCKED
`endif
  } state_t;
  state_t state, state_n;
  logic [TW-1:0] timer, timer_n;
  logic [RW-1:0] tries, tries_n;
  logic [BW-1:0] bcnt;
  logic blink, pass_q, exit_q, pass_edge, exit_edge, inc, dec;
  logic [6:0] free;
  function automatic logic [6:0] seg(input logic [3:0] d);
    case (d)
      4'd0: seg = 7'b1000000;
      4'd1: seg = 7'b1111001;
      4'd2: seg = 7'b0100100;
      4'd3: seg = 7'b0110000;
      4'd4: seg = 7'b0011001;
      4'd5: seg = 7'b0010010;
      4'd6: seg = 7'b0000010;
      4'd7: seg = 7'b1111000;
      4'd8: seg = 7'b0000000;
      4'd9: seg = 7'b0010000;
      default: seg = 7'b1111111;
    endcase
  endfunction
  assign pass_edge = sensor_pass & ~pass_q;
  assign exit_edge = sensor_exit & ~exit_q;
  assign inc = (state == RIGHT_PASS) && pass_edge;
  assign dec = exit_edge;
  assign full = occupancy == CAP;
  assign free = 7'(CAP - occupancy);
  assign HEX_1 = seg(4'(free / 7'd10));
  assign HEX_2 = seg(4'(free % 7'd10));
  always_comb begin
    state_n = state;
    timer_n = timer;
    tries_n = tries;
    case (state)
      IDLE: if (sensor_entrance && !full) begin
        state_n = WAIT_PASSWORD;
        timer_n = '0;
        tries_n = '0;
      end
      WAIT_PASSWORD, WRONG_PASS, STOP: begin
        timer_n = (pw_valid || timer == TO_LAST) ? '0 : timer + TW'(1);
        if (pw_valid) begin
          if (password == PASSWORD) state_n = RIGHT_PASS;
`ifdef PARKING_LOCKOUT_EN
          else if (tries == TRIES_LAST) state_n = LOCKED;
          else begin
            state_n = WRONG_PASS;
            tries_n = tries + RW'(1);
          end
`else
          else state_n = WRONG_PASS;
`endif
        end else if (timer == TO_LAST) state_n = IDLE;
      end
      // the car that just passed counts, so a tailgater needs room for one more
      RIGHT_PASS: if (pass_edge) begin
        state_n = (sensor_entrance && occupancy < CAP_M1) ? STOP : IDLE;
        timer_n = '0;
        tries_n = '0;
      end
`ifdef PARKING_LOCKOUT_EN
      LOCKED: begin
        timer_n = timer == LK_LAST ? '0 : timer + TW'(1);
        if (timer == LK_LAST) begin
          state_n = IDLE;
          tries_n = '0;
        end
      end
`endif
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      occupancy <= '0;
      tries <= '0;
      timer <= '0;
      bcnt <= '0;
      blink <= 1'b0;
      pass_q <= 1'b0;
      exit_q <= 1'b0;
      GREEN_LED <= 1'b0;
      RED_LED <= 1'b0;
    end else begin
      state <= state_n;
      tries <= tries_n;
      timer <= timer_n;
      pass_q <= sensor_pass;
      exit_q <= sensor_exit;
      bcnt <= bcnt == BL_LAST ? '0 : bcnt + BW'(1);
      blink <= bcnt == BL_LAST ? ~blink : blink;
      occupancy <= (inc && !dec && !full) ? occupancy + OW'(1) :
                   (dec && !inc && occupancy != '0) ? occupancy - OW'(1) : occupancy;
      GREEN_LED <= (state == RIGHT_PASS) && blink;
      RED_LED <= state == IDLE ? full :
                 (state == WRONG_PASS || state == STOP) ? blink : state != RIGHT_PASS;
    end
  end
`ifdef PARKING_LOCKOUT_EN
  always_ff @(posedge clk) lockout <= reset ? 1'b0 : state == LOCKED;
`else
  assign lockout = 1'b0;
`endif
endmodule

// File: tb/tb_parking_controller_multi.sv
// tb_parking_controller_multi: vector table plus hand sequences, scoreboard-checked each cycle
module tb_parking_controller_multi;
  localparam int CAP = 8;
  logic clk = 0, reset = 1, se = 0, sp = 0, sx = 0, pv = 0;
  logic [3:0] pw = 0;
  logic green, red, full, lockout;
  logic [3:0] occupancy;
  logic [6:0] hex1, hex2;
  typedef struct {logic e, p, x, v; logic [3:0] pw; int occ, g, r, lk;} vec_t;
  vec_t sb[$];
  vec_t tbl[8];
  int compared = 0, mismatched = 0, ncyc = 0;
  logic [6:0] segs [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                            7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  parking_controller_multi dut (
    .clk(clk), .reset(reset), .sensor_entrance(se), .sensor_pass(sp), .sensor_exit(sx),
    .password(pw), .pw_valid(pv), .GREEN_LED(green), .RED_LED(red), .occupancy(occupancy),
    .full(full), .lockout(lockout), .HEX_1(hex1), .HEX_2(hex2)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, ncyc, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic e, p, x, v, input logic [3:0] w, input int occ, g, r, lk);
    vec_t t;
    t.e = e; t.p = p; t.x = x; t.v = v; t.pw = w; t.occ = occ; t.g = g; t.r = r; t.lk = lk;
    return t;
  endfunction

  // LED codes: 0/1 literal, 2 = current blink phase, 3 = not checked
  task automatic step(input vec_t v);
    vec_t x;
    int bl, fr;
    se = v.e; sp = v.p; sx = v.x; pv = v.v; pw = v.pw;
    sb.push_back(v);
    @(posedge clk);
    ncyc++;
    #1;
    x = sb.pop_front();
    bl = ((ncyc - 1) / 4) % 2;
    fr = CAP - x.occ;
    check("occupancy", occupancy, x.occ);
    check("full", full, x.occ == CAP);
    check("HEX_1", hex1, segs[fr / 10]);
    check("HEX_2", hex2, segs[fr % 10]);
    check("lockout", lockout, x.lk);
    if (x.g != 3) check("GREEN_LED", green, x.g == 2 ? bl : x.g);
    if (x.r != 3) check("RED_LED", red, x.r == 2 ? bl : x.r);
  endtask

  task automatic st(input logic e, p, x, v, input logic [3:0] w, input int occ, g, r, lk);
    step(mk(e, p, x, v, w, occ, g, r, lk));
  endtask

  task automatic do_reset();
    reset = 1; se = 0; sp = 0; sx = 0; pv = 0; pw = 0;
    @(posedge clk);
    #1;
    check("rst occupancy", occupancy, 0);
    check("rst GREEN_LED", green, 0);
    check("rst RED_LED", red, 0);
    check("rst lockout", lockout, 0);
    check("rst full", full, 0);
    check("rst HEX_1", hex1, segs[0]);
    check("rst HEX_2", hex2, segs[8]);
    reset = 0;
    ncyc = 0;
  endtask

  initial begin
    tbl[0] = mk(1, 0, 0, 0, 4'h0, 0, 0, 0, 0);
    tbl[1] = mk(1, 0, 0, 1, 4'hA, 0, 0, 1, 0);
    tbl[2] = mk(0, 0, 0, 0, 4'h0, 0, 2, 0, 0);
    tbl[3] = mk(0, 0, 0, 0, 4'h0, 0, 2, 0, 0);
    tbl[4] = mk(0, 0, 0, 0, 4'h0, 0, 2, 0, 0);
    tbl[5] = mk(0, 1, 0, 0, 4'h0, 1, 2, 0, 0);
    tbl[6] = mk(0, 0, 0, 0, 4'h0, 1, 0, 0, 0);
    tbl[7] = mk(0, 0, 0, 0, 4'h0, 1, 0, 0, 0);
    do_reset();
    for (int i = 0; i < 8; i++) step(tbl[i]);
    // abandoned entry: RED from WAIT_PASSWORD lasts exactly 20 samples
    st(1, 0, 0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 20; i++) st(0, 0, 0, 0, 0, 1, 0, 1, 0);
    st(0, 0, 0, 0, 0, 1, 0, 0, 0);
    // three wrong passwords
    st(1, 0, 0, 0, 0, 1, 0, 0, 0);
    st(0, 0, 0, 1, 4'h3, 1, 0, 1, 0);
    st(0, 0, 0, 1, 4'h3, 1, 0, 2, 0);
    st(0, 0, 0, 1, 4'h3, 1, 0, 2, 0);
`ifdef PARKING_LOCKOUT_EN
    for (int i = 0; i < 50; i++) st(0, 0, 0, i == 10, 4'hA, 1, 0, 1, 1);
`else
    for (int i = 0; i < 20; i++) st(0, 0, 0, 0, 0, 1, 0, 2, 0);
`endif
    st(0, 0, 0, 0, 0, 1, 0, 0, 0);
    st(0, 0, 0, 0, 0, 1, 0, 0, 0);
    // tailgater held at the gate
    st(1, 0, 0, 0, 0, 1, 0, 0, 0);
    st(1, 0, 0, 1, 4'hA, 1, 0, 1, 0);
    st(1, 1, 0, 0, 0, 2, 2, 0, 0);
    st(1, 1, 0, 0, 0, 2, 0, 2, 0);
    for (int i = 0; i < 6; i++) st(0, 0, 0, 0, 0, 2, 0, 2, 0);
    st(0, 0, 0, 1, 4'hA, 2, 0, 2, 0);
    st(0, 0, 0, 0, 0, 2, 2, 0, 0);
    st(0, 1, 0, 0, 0, 3, 2, 0, 0);
    st(0, 0, 0, 0, 0, 3, 0, 0, 0);
    // simultaneous pass and exit, then drain to zero and one extra exit
    st(1, 0, 0, 0, 0, 3, 0, 0, 0);
    st(0, 0, 0, 1, 4'hA, 3, 0, 1, 0);
    st(0, 1, 1, 0, 0, 3, 2, 0, 0);
    st(0, 0, 0, 0, 0, 3, 0, 0, 0);
    for (int i = 2; i >= -1; i--) begin
      st(0, 0, 1, 0, 0, i < 0 ? 0 : i, 0, 0, 0);
      st(0, 0, 0, 0, 0, i < 0 ? 0 : i, 0, 0, 0);
    end
    // fill the lot
    for (int c = 0; c < CAP; c++) begin
      st(1, 0, 0, 0, 0, c, 3, 3, 0);
      st(0, 0, 0, 1, 4'hA, c, 3, 3, 0);
      st(0, 1, 0, 0, 0, c + 1, 3, 3, 0);
      st(0, 0, 0, 0, 0, c + 1, 3, 3, 0);
    end
    st(0, 0, 0, 0, 0, CAP, 0, 1, 0);
    st(1, 0, 0, 0, 0, CAP, 0, 1, 0);
    st(0, 0, 0, 1, 4'hA, CAP, 0, 1, 0);
    st(0, 0, 0, 0, 0, CAP, 0, 1, 0);
    st(0, 0, 0, 0, 0, CAP, 0, 1, 0);
    st(0, 0, 1, 0, 0, CAP - 1, 0, 1, 0);
    st(0, 0, 0, 0, 0, CAP - 1, 0, 0, 0);
    // last free slot with entrance still held: no STOP, lot full
    st(1, 0, 0, 0, 0, CAP - 1, 0, 0, 0);
    st(1, 0, 0, 1, 4'hA, CAP - 1, 0, 1, 0);
    st(1, 1, 0, 0, 0, CAP, 2, 0, 0);
    for (int i = 0; i < 5; i++) st(1, 1, 0, 0, 0, CAP, 0, 1, 0);
    // reset in the middle of WRONG_PASS
    st(0, 0, 1, 0, 0, CAP - 1, 0, 1, 0);
    st(0, 0, 0, 0, 0, CAP - 1, 0, 0, 0);
    st(1, 0, 0, 0, 0, CAP - 1, 0, 0, 0);
    st(0, 0, 0, 1, 4'h3, CAP - 1, 0, 1, 0);
    st(0, 0, 0, 0, 0, CAP - 1, 0, 2, 0);
    do_reset();
    st(0, 0, 0, 0, 0, 0, 0, 0, 0);
    st(0, 0, 0, 0, 0, 0, 0, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
